cpu_mem_arbiter: RTL and testbench

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

---
 rtl/cpu_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares a single burst-oriented memory port between
// NUM_CH requesters (channel 0 = I-cache, channel 1 = D-cache).
// Each winner owns the port for a full BURST_LEN-beat transaction.
// Arbitration is fixed priority (ARB_MODE=0) or round-robin (ARB_MODE=1).
//
// Memory handshake (memValid/memReady): a beat transfers in every cycle where
// memValid and memReady are both high. While memValid is high and memReady is
// low, memAdr and memWrite stay stable and the beat counter holds. memWData is
// a live mux of the winner's reqWData, so the requester keeps its data stable
// until it sees its reqBeat strobe.
module cpu_mem_arbiter #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_CH      = 2,
  parameter int BURST_LEN   = 4,
  parameter int ARB_MODE    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             reqValid,
  input  logic [NUM_CH-1:0]             reqWrite,
  input  logic [NUM_CH*WORD_LENGTH-1:0] reqAdr,
  input  logic [NUM_CH*WORD_LENGTH-1:0] reqWData,
  output logic [NUM_CH-1:0]             reqGrant,
  output logic [NUM_CH-1:0]             reqBeat,
  output logic [NUM_CH-1:0]             reqDone,
  output logic [WORD_LENGTH-1:0]        reqRData,
  output logic                          memValid,
  output logic                          memWrite,
  output logic [WORD_LENGTH-1:0]        memAdr,
  output logic [WORD_LENGTH-1:0]        memWData,
  input  logic                          memReady,
  input  logic [WORD_LENGTH-1:0]        memRData,
  output logic                          busy
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BYTES = WORD_LENGTH / 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT                   state;
  stateT                   nextState;

  // Transaction context captured at grant time; later request changes are ignored.
  logic [IDX_W-1:0]        winnerIdx;
  logic [WORD_LENGTH-1:0]  baseAdr;
  logic                    writeLatched;
  logic [CNT_W-1:0]        beatCnt;
  logic [IDX_W-1:0]        lastGrant;
  logic [NUM_CH-1:0]       grantQ;

  logic                    arbFound;
  logic [IDX_W-1:0]        arbIdx;
  int                      bestDist;
  int                      chDist;

  logic [WORD_LENGTH-1:0]  adrArr   [NUM_CH];
  logic [WORD_LENGTH-1:0]  wDataArr [NUM_CH];
  logic [NUM_CH-1:0]       winnerOneHot;
  logic [WORD_LENGTH-1:0]  beatAdr;

  // Split the flat per-channel buses into word arrays for indexed selection.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      adrArr[c]   = reqAdr[c*WORD_LENGTH +: WORD_LENGTH];
      wDataArr[c] = reqWData[c*WORD_LENGTH +: WORD_LENGTH];
    end
  end

  // Pick the requester closest to the search start: channel 0 in fixed mode,
  // lastGrant+1 (mod NUM_CH) in round-robin mode.
  always_comb begin
    arbFound = 1'b0;
    arbIdx   = '0;
    bestDist = NUM_CH;
    chDist   = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ARB_MODE == 1 && NUM_CH > 1) begin
        chDist = (c + NUM_CH - 1 - int'(lastGrant)) % NUM_CH;
      end else begin
        chDist = c;
      end
      if (reqValid[c] && (chDist < bestDist)) begin
        arbFound = 1'b1;
        bestDist = chDist;
        arbIdx   = IDX_W'(c);
      end
    end
  end

  assign winnerOneHot = NUM_CH'(1) << winnerIdx;
  // Wraps modulo 2^WORD_LENGTH by truncation.
  assign beatAdr      = baseAdr + (WORD_LENGTH'(beatCnt) * WORD_LENGTH'(BYTES));
  assign reqGrant     = grantQ;

  // State register; reset drops straight to IDLE, abandoning any burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state and all combinational outputs; everything is zero outside BUSY/DONE.
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    memValid  = 1'b0;
    memWrite  = 1'b0;
    memAdr    = '0;
    memWData  = '0;
    reqRData  = '0;
    reqBeat   = '0;
    reqDone   = '0;
    case (state)
      IDLE: begin
        if (arbFound) begin
          nextState = BUSY;
        end
      end
      BUSY: begin
        busy     = 1'b1;
        memValid = 1'b1;
        memWrite = writeLatched;
        memAdr   = beatAdr;
        memWData = wDataArr[winnerIdx];
        reqRData = memRData;
        if (memReady) begin
          reqBeat = winnerOneHot;
          if (beatCnt == LAST_BEAT) begin
            nextState = DONE;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        reqDone   = winnerOneHot;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Capture the winner's context on grant, advance the beat counter, drop the grant after DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winnerIdx    <= '0;
      baseAdr      <= '0;
      writeLatched <= 1'b0;
      beatCnt      <= '0;
      lastGrant    <= IDX_W'(NUM_CH - 1);
      grantQ       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arbFound) begin
            winnerIdx    <= arbIdx;
            baseAdr      <= adrArr[arbIdx];
            writeLatched <= reqWrite[arbIdx];
            beatCnt      <= '0;
            lastGrant    <= arbIdx;
            grantQ       <= NUM_CH'(1) << arbIdx;
          end
        end
        BUSY: begin
          if (memReady && (beatCnt != LAST_BEAT)) begin
            beatCnt <= beatCnt + CNT_W'(1);
          end
        end
        default: begin
          grantQ <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: a fixed-priority instance carries the
// burst, wait-state, write, wrap and reset scenarios; a round-robin instance
// with its own request vector checks grant alternation.
module tb_cpu_mem_arbiter;

  localparam int W   = 32;
  localparam int NCH = 2;
  localparam int BL  = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus
  logic [NCH-1:0]   reqValid;
  logic [NCH-1:0]   reqWrite;
  logic [NCH*W-1:0] reqAdr;
  logic [NCH*W-1:0] reqWData;
  logic             memReady;
  logic [W-1:0]     memRData;

  // Fixed-priority instance outputs
  logic [NCH-1:0] reqGrant, reqBeat, reqDone;
  logic [W-1:0]   reqRData, memAdr, memWData;
  logic           memValid, memWrite, busy;

  // Round-robin instance
  logic [NCH-1:0] rrValid;
  logic [NCH-1:0] rrGrant, rrBeat, rrDone;
  logic [W-1:0]   rrRData, rrMemAdr, rrMemWData;
  logic           rrMemValid, rrMemWrite, rrBusy;

  cpu_mem_arbiter #(.WORD_LENGTH(W), .NUM_CH(NCH), .BURST_LEN(BL), .ARB_MODE(0)) dutFix (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqWrite(reqWrite), .reqAdr(reqAdr), .reqWData(reqWData),
    .reqGrant(reqGrant), .reqBeat(reqBeat), .reqDone(reqDone), .reqRData(reqRData),
    .memValid(memValid), .memWrite(memWrite), .memAdr(memAdr), .memWData(memWData),
    .memReady(memReady), .memRData(memRData), .busy(busy)
  );

  cpu_mem_arbiter #(.WORD_LENGTH(W), .NUM_CH(NCH), .BURST_LEN(BL), .ARB_MODE(1)) dutRr (
    .clk(clk), .rst(rst),
    .reqValid(rrValid), .reqWrite(reqWrite), .reqAdr(reqAdr), .reqWData(reqWData),
    .reqGrant(rrGrant), .reqBeat(rrBeat), .reqDone(rrDone), .reqRData(rrRData),
    .memValid(rrMemValid), .memWrite(rrMemWrite), .memAdr(rrMemAdr), .memWData(rrMemWData),
    .memReady(memReady), .memRData(memRData), .busy(rrBusy)
  );

  // Scoreboard: expected memory addresses, one per beat, in order
  logic [W-1:0] expQ[$];
  int assertCnt = 0;
  int failCnt   = 0;
  int cyc;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic setAdr(input int ch, input logic [W-1:0] a);
    reqAdr[ch*W +: W] = a;
  endtask

  task automatic pushBurst(input logic [W-1:0] base);
    logic [W-1:0] a;
    for (int i = 0; i < BL; i++) begin
      a = base + W'(4 * i);
      expQ.push_back(a);
    end
  endtask

  // Drives one burst from its first BUSY cycle through DONE.
  task automatic serveBurst(input int ch, input logic isWrite, input int waitBeat,
                            input int waitCycles, input logic scramble, output int cycles);
    int b;
    int stallLeft;
    logic stall;
    logic [NCH-1:0] oneHot;
    b = 0;
    cycles = 0;
    stallLeft = waitCycles;
    oneHot = NCH'(1) << ch;
    while (b < BL && cycles < 40) begin
      @(negedge clk);
      stall = (b == waitBeat) && (stallLeft > 0);
      memReady = !stall;
      memRData = $urandom;
      reqWData[ch*W +: W] = 32'hA0 + 32'(b);
      if (scramble) setAdr(ch, $urandom);
      #1;
      checkEq("busy", 64'(busy), 64'(1));
      checkEq("memValid", 64'(memValid), 64'(1));
      checkEq("reqGrant", 64'(reqGrant), 64'(oneHot));
      checkEq("memWrite", 64'(memWrite), 64'(isWrite));
      if (expQ.size() != 0) checkEq("memAdr", 64'(memAdr), 64'(expQ[0]));
      else checkEq("expQSize", 64'(expQ.size()), 64'(1));
      if (isWrite) checkEq("memWData", 64'(memWData), 64'(32'hA0 + 32'(b)));
      checkEq("reqBeat", 64'(reqBeat), 64'(stall ? '0 : oneHot));
      if (!stall && !isWrite) checkEq("reqRData", 64'(reqRData), 64'(memRData));
      checkEq("reqDoneBusy", 64'(reqDone), 64'(0));
      cycles++;
      if (stall) stallLeft--;
      else begin
        void'(expQ.pop_front());
        b++;
      end
    end
    @(negedge clk);
    memReady = 1'b1;
    reqValid[ch] = 1'b0;
    #1;
    checkEq("reqDone", 64'(reqDone), 64'(oneHot));
    checkEq("doneMemValid", 64'(memValid), 64'(0));
    checkEq("doneBusy", 64'(busy), 64'(1));
    checkEq("doneGrant", 64'(reqGrant), 64'(oneHot));
    checkEq("doneBeat", 64'(reqBeat), 64'(0));
  endtask

  task automatic idleCheck(input string tag);
    @(negedge clk);
    #1;
    checkEq({tag, "Busy"}, 64'(busy), 64'(0));
    checkEq({tag, "Grant"}, 64'(reqGrant), 64'(0));
    checkEq({tag, "MemValid"}, 64'(memValid), 64'(0));
    checkEq({tag, "Done"}, 64'(reqDone), 64'(0));
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios
  initial begin
    logic [NCH-1:0] rrExp;
    rst = 1'b0;
    reqValid = '0; reqWrite = '0; reqAdr = '0; reqWData = '0;
    memReady = 1'b0; memRData = 32'hDEADBEEF; rrValid = '0;

    // Reset state (a rising clock edge passes with reset held low)
    #7;
    checkEq("rstBusy", 64'(busy), 64'(0));
    checkEq("rstGrant", 64'(reqGrant), 64'(0));
    checkEq("rstMemValid", 64'(memValid), 64'(0));
    checkEq("rstRData", 64'(reqRData), 64'(0));
    checkEq("rstRrBusy", 64'(rrBusy), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Fixed priority: both request together, ch0 first, one idle cycle, then ch1
    @(negedge clk);
    reqValid = 2'b11;
    setAdr(0, 32'h100);
    setAdr(1, 32'h200);
    memReady = 1'b1;
    #1;
    checkEq("preGrant", 64'(reqGrant), 64'(0));
    pushBurst(32'h100);
    serveBurst(0, 1'b0, -1, 0, 1'b0, cyc);
    checkEq("fixCycles", 64'(cyc), 64'(BL));
    idleCheck("gap");
    pushBurst(32'h200);
    serveBurst(1, 1'b0, -1, 0, 1'b0, cyc);
    idleCheck("fixEnd");

    // Wait states: memReady low for 3 cycles on beat 2
    @(negedge clk);
    reqValid[0] = 1'b1;
    setAdr(0, 32'h100);
    pushBurst(32'h100);
    serveBurst(0, 1'b0, 2, 3, 1'b0, cyc);
    checkEq("waitCycles", 64'(cyc), 64'(BL + 3));
    idleCheck("waitEnd");

    // Write burst on ch1
    @(negedge clk);
    reqValid[1] = 1'b1;
    reqWrite[1] = 1'b1;
    setAdr(1, 32'h500);
    pushBurst(32'h500);
    serveBurst(1, 1'b1, -1, 0, 1'b0, cyc);
    reqWrite[1] = 1'b0;
    idleCheck("wrEnd");

    // Address wrap; request address scrambled mid-burst must not matter
    @(negedge clk);
    reqValid[0] = 1'b1;
    setAdr(0, 32'hFFFF_FFF8);
    pushBurst(32'hFFFF_FFF8);
    serveBurst(0, 1'b0, -1, 0, 1'b1, cyc);
    idleCheck("wrapEnd");

    // Round-robin: both request continuously -> 0,1,0,1
    @(negedge clk);
    rrValid = 2'b11;
    memReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rrExp = NCH'(1) << (k % 2);
      for (int t = 0; t < 12; t++) begin
        @(negedge clk);
        #1;
        if (rrGrant != '0) break;
      end
      checkEq("rrGrant", 64'(rrGrant), 64'(rrExp));
      for (int t = 0; t < 12; t++) begin
        @(negedge clk);
        #1;
        if (rrDone != '0) break;
      end
      checkEq("rrDone", 64'(rrDone), 64'(rrExp));
    end
    rrValid = '0;
    @(negedge clk);
    #1;
    checkEq("rrIdle", 64'(rrBusy), 64'(0));

    // Async reset during BUSY beat 1
    @(negedge clk);
    reqValid = 2'b01;
    setAdr(0, 32'h300);
    memReady = 1'b1;
    memRData = 32'h1234_5678;
    @(negedge clk);
    #1;
    checkEq("rbBeat0Adr", 64'(memAdr), 64'(32'h300));
    @(negedge clk);
    #1;
    checkEq("rbBeat1Adr", 64'(memAdr), 64'(32'h304));
    checkEq("rbBeat1Beat", 64'(reqBeat), 64'(2'b01));
    #2;
    rst = 1'b0;
    #1;
    checkEq("arGrant", 64'(reqGrant), 64'(0));
    checkEq("arBeat", 64'(reqBeat), 64'(0));
    checkEq("arDone", 64'(reqDone), 64'(0));
    checkEq("arMemValid", 64'(memValid), 64'(0));
    checkEq("arMemWrite", 64'(memWrite), 64'(0));
    checkEq("arMemAdr", 64'(memAdr), 64'(0));
    checkEq("arMemWData", 64'(memWData), 64'(0));
    checkEq("arRData", 64'(reqRData), 64'(0));
    checkEq("arBusy", 64'(busy), 64'(0));
    @(negedge clk);
    #1;
    checkEq("arHoldDone", 64'(reqDone), 64'(0));
    checkEq("arHoldBusy", 64'(busy), 64'(0));
    reqValid = 2'b10;
    setAdr(1, 32'h400);
    rst = 1'b1;
    pushBurst(32'h400);
    serveBurst(1, 1'b0, -1, 0, 1'b0, cyc);
    idleCheck("postRst");

    checkEq("expQEmpty", 64'(expQ.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
